// File: rtl/noc_pkg.sv
// noc_pkg
// Shared definitions for the 4x4 mesh switch.
//   - ra_state_t : per-input route allocator FSM states (2-bit encoding).
//   - DIR_*      : mesh direction / port indices, also used by MuxSwitch.
// No ports (package).
package noc_pkg;

    localparam logic [1:0] RA_IDLE  = 2'd0;
    localparam logic [1:0] RA_WAIT  = 2'd1;
    localparam logic [1:0] RA_GRANT = 2'd2;
    localparam logic [1:0] RA_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = RA_IDLE,
        ST_WAIT  = RA_WAIT,
        ST_GRANT = RA_GRANT,
        ST_HOLD  = RA_HOLD
    } ra_state_t;

    localparam int DIR_NORTH = 0;
    localparam int DIR_SOUTH = 1;
    localparam int DIR_WEST  = 2;
    localparam int DIR_EAST  = 3;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. The search for a set request
// starts at index ptr and wraps upward modulo N.
// Ports:
//   req    [N]      : request vector
//   ptr    [IW]     : index with highest priority this cycle
//   gnt    [N]      : one-hot grant (all zero when no request)
//   gntIdx [IW]     : index of the granted requester
//   anyGnt          : at least one request was granted
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gntIdx,
    output logic          anyGnt
);

    always_comb begin
        int idx;
        gnt    = '0;
        gntIdx = '0;
        anyGnt = 1'b0;
        idx    = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!anyGnt && req[idx]) begin
                gnt[idx] = 1'b1;
                gntIdx   = IW'(idx);
                anyGnt   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/route_allocator.sv
// route_allocator
// Reserves switch paths: each input asks for one output, each free output
// is handed to one waiting input by its own round-robin arbiter, and the
// path is held until the owning input relieves it.
// Ports:
//   clk, rst                 : clock and synchronous active-high reset
//   routeReserveRequestValid : per-input request valid
//   routeReserveRequest      : per-input requested output index
//   routeRelieve             : per-input path release (after tail flit)
//   routeReserveStatus       : one-cycle grant pulse per input
//   routeHeld                : input currently owns a path
//   routeSelect              : owning input index per output (to MuxSwitch)
//   outputValid              : output currently connected
module route_allocator
    import noc_pkg::*;
#(
    parameter int INPUTS        = 4,
    parameter int OUTPUTS       = 4,
    parameter int REQUEST_WIDTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [INPUTS-1:0]                   routeReserveRequestValid,
    input  logic [INPUTS*REQUEST_WIDTH-1:0]     routeReserveRequest,
    input  logic [INPUTS-1:0]                   routeRelieve,
    output logic [INPUTS-1:0]                   routeReserveStatus,
    output logic [INPUTS-1:0]                   routeHeld,
    output logic [OUTPUTS*$clog2(INPUTS)-1:0]   routeSelect,
    output logic [OUTPUTS-1:0]                  outputValid
);

    localparam int SEL_W = $clog2(INPUTS);

    ra_state_t                state      [INPUTS];
    ra_state_t                state_next [INPUTS];
    logic [REQUEST_WIDTH-1:0] owner      [INPUTS];
    logic [INPUTS-1:0]        won;

    logic [OUTPUTS-1:0]       busy;
    logic [SEL_W-1:0]         rr_ptr     [OUTPUTS];
    logic [SEL_W-1:0]         sel_q      [OUTPUTS];

    logic [INPUTS-1:0]        arb_req    [OUTPUTS];
    logic [INPUTS-1:0]        arb_gnt    [OUTPUTS];
    logic [SEL_W-1:0]         arb_idx    [OUTPUTS];
    logic                     arb_any    [OUTPUTS];

    // Candidates are live, waiting requests for this output. A busy output
    // has all candidates masked, so it never arbitrates. Indices >= OUTPUTS
    // match no output and therefore wait forever.
    always_comb begin
        for (int o = 0; o < OUTPUTS; o++) begin
            arb_req[o] = '0;
            for (int i = 0; i < INPUTS; i++) begin
                arb_req[o][i] = (state[i] == ST_WAIT)
                             && routeReserveRequestValid[i]
                             && (routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH]
                                 == REQUEST_WIDTH'(o))
                             && !busy[o];
            end
        end
    end

    for (genvar o = 0; o < OUTPUTS; o++) begin : g_arb
        rr_arbiter #(.N(INPUTS), .IW(SEL_W)) u_arb (
            .req    (arb_req[o]),
            .ptr    (rr_ptr[o]),
            .gnt    (arb_gnt[o]),
            .gntIdx (arb_idx[o]),
            .anyGnt (arb_any[o])
        );
    end

    // An input requests a single output, so at most one arbiter can pick it.
    always_comb begin
        won = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            won = won | arb_gnt[o];
        end
    end

    // Per-input FSM next state. Relieve wins over the GRANT->HOLD step.
    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            state_next[i] = state[i];
            case (state[i])
                ST_IDLE:  if (routeReserveRequestValid[i]) state_next[i] = ST_WAIT;
                ST_WAIT: begin
                    if (!routeReserveRequestValid[i]) state_next[i] = ST_IDLE;
                    else if (won[i])                  state_next[i] = ST_GRANT;
                end
                ST_GRANT: state_next[i] = routeRelieve[i] ? ST_IDLE : ST_HOLD;
                ST_HOLD:  if (routeRelieve[i]) state_next[i] = ST_IDLE;
                default:  state_next[i] = ST_IDLE;
            endcase
        end
    end

    // State, ownership and per-output path registers. A grant and a relieve
    // can never hit the same output in one cycle, since grants require the
    // output to be idle and relieves only come from its owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < INPUTS; i++) begin
                state[i] <= ST_IDLE;
                owner[i] <= '0;
            end
            for (int o = 0; o < OUTPUTS; o++) begin
                rr_ptr[o] <= '0;
                sel_q[o]  <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < INPUTS; i++) begin
                state[i] <= state_next[i];
                if (won[i]) begin
                    owner[i] <= routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH];
                end
            end
            for (int o = 0; o < OUTPUTS; o++) begin
                if (arb_any[o]) begin
                    busy[o]   <= 1'b1;
                    sel_q[o]  <= arb_idx[o];
                    rr_ptr[o] <= (arb_idx[o] == SEL_W'(INPUTS - 1)) ? '0 : arb_idx[o] + 1'b1;
                end
            end
            // Free the output latched at grant time, not the live request.
            for (int i = 0; i < INPUTS; i++) begin
                if (((state[i] == ST_GRANT) || (state[i] == ST_HOLD)) && routeRelieve[i]) begin
                    busy[owner[i]] <= 1'b0;
                end
            end
        end
    end

    // Outputs decode registers only; no input reaches an output combinationally.
    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            routeReserveStatus[i] = (state[i] == ST_GRANT);
            routeHeld[i]          = (state[i] == ST_GRANT) || (state[i] == ST_HOLD);
        end
        for (int o = 0; o < OUTPUTS; o++) begin
            routeSelect[o*SEL_W +: SEL_W] = sel_q[o];
        end
        outputValid = busy;
    end

endmodule

// File: tb/tb_route_allocator.sv
// tb_route_allocator
// Directed bench for route_allocator. A second instance with OUTPUTS=3 is
// used for the out-of-range request case.
// Ports: none (top-level bench).
module tb_route_allocator;

    logic       clk;
    logic       rst;
    logic [3:0] reqValid;
    logic [7:0] reqIdx;
    logic [3:0] relieve;
    logic [3:0] status;
    logic [3:0] held;
    logic [7:0] select;
    logic [3:0] outValid;

    logic [3:0] reqValid3;
    logic [7:0] reqIdx3;
    logic [3:0] relieve3;
    logic [3:0] status3;
    logic [3:0] held3;
    logic [5:0] select3;
    logic [2:0] outValid3;

    int checks = 0;
    int errors = 0;

    route_allocator #(.INPUTS(4), .OUTPUTS(4), .REQUEST_WIDTH(2)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .routeReserveRequestValid (reqValid),
        .routeReserveRequest      (reqIdx),
        .routeRelieve             (relieve),
        .routeReserveStatus       (status),
        .routeHeld                (held),
        .routeSelect              (select),
        .outputValid              (outValid)
    );

    route_allocator #(.INPUTS(4), .OUTPUTS(3), .REQUEST_WIDTH(2)) dut3 (
        .clk                      (clk),
        .rst                      (rst),
        .routeReserveRequestValid (reqValid3),
        .routeReserveRequest      (reqIdx3),
        .routeRelieve             (relieve3),
        .routeReserveStatus       (status3),
        .routeHeld                (held3),
        .routeSelect              (select3),
        .outputValid              (outValid3)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the main instance's request/relieve inputs.
    task automatic applyStimulus(input logic [3:0] v, input logic [7:0] r, input logic [3:0] rl);
        reqValid = v;
        reqIdx   = r;
        relieve  = rl;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed scenario sequence.
    initial begin
        rst = 1'b1;
        applyStimulus(4'b0000, 8'h00, 4'b0000);
        reqValid3 = '0;
        reqIdx3   = '0;
        relieve3  = '0;
        tick(2);
        rst = 1'b0;

        // Reset values
        checkOutput("reset_status",   status,   0);
        checkOutput("reset_held",     held,     0);
        checkOutput("reset_select",   select,   0);
        checkOutput("reset_outvalid", outValid, 0);

        // Single request: input 2 -> output 3 (field 2 = bits [5:4])
        applyStimulus(4'b0100, 8'b00_11_00_00, 4'b0000);
        tick();
        checkOutput("single_wait_status", status, 0);
        tick();
        checkOutput("single_grant_status", status,      4'b0100);
        checkOutput("single_select3",      select[7:6], 2);
        checkOutput("single_outvalid",     outValid,    4'b1000);
        checkOutput("single_held",         held,        4'b0100);
        applyStimulus(4'b0000, 8'h00, 4'b0000);
        tick();
        checkOutput("single_pulse_end", status, 0);
        checkOutput("single_hold_held", held,   4'b0100);
        applyStimulus(4'b0000, 8'h00, 4'b0100);
        tick();
        checkOutput("single_relieved_outvalid", outValid,    0);
        checkOutput("single_relieved_held",     held,        0);
        checkOutput("single_select_retained",   select[7:6], 2);
        applyStimulus(4'b0000, 8'h00, 4'b0000);

        // Contention: inputs 0,1,3 request output 1
        applyStimulus(4'b1011, 8'b01_00_01_01, 4'b0000);
        tick(2);
        checkOutput("cont_grant0_status", status,      4'b0001);
        checkOutput("cont_grant0_select", select[3:2], 0);
        checkOutput("cont_grant0_ov",     outValid,    4'b0010);
        applyStimulus(4'b1010, 8'b01_00_01_01, 4'b0000);
        tick();
        applyStimulus(4'b1010, 8'b01_00_01_01, 4'b0001);
        tick();
        checkOutput("cont_relieve0_ov",     outValid, 0);
        checkOutput("cont_no_handover",     status,   0);
        applyStimulus(4'b1010, 8'b01_00_01_01, 4'b0000);
        tick();
        checkOutput("cont_grant1_status", status,      4'b0010);
        checkOutput("cont_grant1_select", select[3:2], 1);
        applyStimulus(4'b1000, 8'b01_00_01_01, 4'b0000);
        tick();
        applyStimulus(4'b1000, 8'b01_00_01_01, 4'b0010);
        tick();
        applyStimulus(4'b1000, 8'b01_00_01_01, 4'b0000);
        tick();
        checkOutput("cont_grant3_status", status,      4'b1000);
        checkOutput("cont_grant3_select", select[3:2], 3);
        applyStimulus(4'b0000, 8'h00, 4'b0000);
        tick();
        applyStimulus(4'b0000, 8'h00, 4'b1000);
        tick();
        applyStimulus(4'b0000, 8'h00, 4'b0000);
        // Pointer wrapped to 0: input 0 beats input 3 again
        applyStimulus(4'b1001, 8'b01_00_00_01, 4'b0000);
        tick(2);
        checkOutput("cont_ptr_wrap_status", status, 4'b0001);
        applyStimulus(4'b0000, 8'h00, 4'b0000);
        tick();
        applyStimulus(4'b0000, 8'h00, 4'b0001);
        tick();
        applyStimulus(4'b0000, 8'h00, 4'b0000);
        checkOutput("cont_cleanup_ov", outValid, 0);

        // Parallel grants: inputs 0..3 -> outputs 3,2,1,0
        applyStimulus(4'b1111, 8'b00_01_10_11, 4'b0000);
        tick(2);
        checkOutput("par_status",   status,   4'b1111);
        checkOutput("par_select",   select,   8'h1B);
        checkOutput("par_outvalid", outValid, 4'b1111);
        applyStimulus(4'b0000, 8'h00, 4'b0000);
        tick();
        checkOutput("par_held", held, 4'b1111);

        // Reset while all paths are held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_mid_ov",     outValid, 0);
        checkOutput("rst_mid_held",   held,     0);
        checkOutput("rst_mid_select", select,   0);
        checkOutput("rst_mid_status", status,   0);
        applyStimulus(4'b0010, 8'b00_00_00_00, 4'b0000);
        tick(2);
        checkOutput("rst_after_status", status, 4'b0010);
        checkOutput("rst_after_select", select, 8'h01);
        applyStimulus(4'b0000, 8'h00, 4'b0000);
        tick();
        applyStimulus(4'b0000, 8'h00, 4'b0010);
        tick();
        applyStimulus(4'b0000, 8'h00, 4'b0000);

        // Withdraw: input 1 waits on busy output 0, then drops valid
        applyStimulus(4'b0001, 8'h00, 4'b0000);
        tick(2);
        checkOutput("wd_owner_status", status, 4'b0001);
        applyStimulus(4'b0010, 8'h00, 4'b0000);
        tick(2);
        checkOutput("wd_waiting_status", status, 0);
        checkOutput("wd_waiting_held",   held,   4'b0001);
        applyStimulus(4'b0000, 8'h00, 4'b0000);
        tick();
        applyStimulus(4'b0000, 8'h00, 4'b0001);
        tick();
        applyStimulus(4'b0000, 8'h00, 4'b0000);
        tick(2);
        checkOutput("wd_no_grant_status", status,   0);
        checkOutput("wd_no_grant_ov",     outValid, 0);
        checkOutput("wd_no_grant_held",   held,     0);

        // Relieve while idle changes nothing
        applyStimulus(4'b0000, 8'h00, 4'b1111);
        tick();
        applyStimulus(4'b0000, 8'h00, 4'b0000);
        tick();
        checkOutput("idle_relieve_held",   held,     0);
        checkOutput("idle_relieve_status", status,   0);
        checkOutput("idle_relieve_ov",     outValid, 0);

        // OUTPUTS=3: input 0 asks for output 3 (never), input 1 for output 2
        reqValid3 = 4'b0011;
        reqIdx3   = 8'b00_00_10_11;
        tick(2);
        checkOutput("o3_status",   status3,      4'b0010);
        checkOutput("o3_outvalid", outValid3,    3'b100);
        checkOutput("o3_select2",  select3[5:4], 1);
        reqValid3 = 4'b0001;
        tick(3);
        checkOutput("o3_oob_status", status3,   0);
        checkOutput("o3_oob_held",   held3,     4'b0010);
        checkOutput("o3_oob_ov",     outValid3, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
